neuron_sad_subtract_accumulate: RTL and testbench

- Streaming sum-of-absolute-differences (SAD) engine for the neuron datapath. It is the subtract/reduce counterpart of the 8-bit Sklansky prefix adder.
- Accepts N_SAMPLES pairs (a, b) over a valid/ready handshake and computes each |a-b| with a Sklansky prefix subtractor (a + ~b + 1).
- Accumulates the differences and presents one SAD result per frame through a valid/ready output handshake.

---
 rtl/neuron_sad_pkg.sv | 18 +
 rtl/neuron_sad_subtractor.sv | 71 +++++++
 rtl/neuron_sad_subtract_accumulate.sv | 85 ++++++++
 tb/tb_neuron_sad_subtract_accumulate.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/neuron_sad_pkg.sv
// Shared types and sizing helpers for the neuron SAD engine.
package neuron_sad_pkg;

  localparam int WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    HOLD
  } state_t;

  // Result width that can hold n_samples maximal differences without overflow.
  function automatic int acc_width(input int width, input int n_samples);
    return width + $clog2(n_samples);
  endfunction

endpackage

// File: rtl/neuron_sad_subtractor.sv
// Prefix-network leaf cells and the 8-bit Sklansky subtractor d = a + ~b + 1.
module generate_propagate (
  input  logic a,
  input  logic b,
  output logic g,
  output logic p
);
  assign g = a & b;
  assign p = a ^ b;
endmodule

module black_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g,
  output logic p
);
  assign g = g_hi | (p_hi & g_lo);
  assign p = p_hi & p_lo;
endmodule

module gray_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  output logic g
);
  assign g = g_hi | (p_hi & g_lo);
endmodule

module sklansky_subtractor_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] d,
  output logic       cout
);
  logic [7:0] g, p, c;
  logic [7:0] b_inv;
  logic g21, p21, g43, p43, g65, p65, g53, p53, g63, p63;

  // Carry-in of 1 acts as a generate at bit -1, so c[i] is the carry out of bit i.
  localparam logic CIN = 1'b1;

  assign b_inv = ~b;

  for (genvar i = 0; i < 8; i++) begin : g_gp
    generate_propagate u_gp (.a(a[i]), .b(b_inv[i]), .g(g[i]), .p(p[i]));
  end

  gray_cell  u_l1_0 (.g_hi(g[0]), .p_hi(p[0]), .g_lo(CIN), .g(c[0]));
  black_cell u_l1_2 (.g_hi(g[2]), .p_hi(p[2]), .g_lo(g[1]), .p_lo(p[1]), .g(g21), .p(p21));
  black_cell u_l1_4 (.g_hi(g[4]), .p_hi(p[4]), .g_lo(g[3]), .p_lo(p[3]), .g(g43), .p(p43));
  black_cell u_l1_6 (.g_hi(g[6]), .p_hi(p[6]), .g_lo(g[5]), .p_lo(p[5]), .g(g65), .p(p65));

  gray_cell  u_l2_1 (.g_hi(g[1]), .p_hi(p[1]), .g_lo(c[0]), .g(c[1]));
  gray_cell  u_l2_2 (.g_hi(g21),  .p_hi(p21),  .g_lo(c[0]), .g(c[2]));
  black_cell u_l2_5 (.g_hi(g[5]), .p_hi(p[5]), .g_lo(g43), .p_lo(p43), .g(g53), .p(p53));
  black_cell u_l2_6 (.g_hi(g65),  .p_hi(p65),  .g_lo(g43), .p_lo(p43), .g(g63), .p(p63));

  gray_cell  u_l3_3 (.g_hi(g[3]), .p_hi(p[3]), .g_lo(c[2]), .g(c[3]));
  gray_cell  u_l3_4 (.g_hi(g43),  .p_hi(p43),  .g_lo(c[2]), .g(c[4]));
  gray_cell  u_l3_5 (.g_hi(g53),  .p_hi(p53),  .g_lo(c[2]), .g(c[5]));
  gray_cell  u_l3_6 (.g_hi(g63),  .p_hi(p63),  .g_lo(c[2]), .g(c[6]));

  gray_cell  u_l4_7 (.g_hi(g[7]), .p_hi(p[7]), .g_lo(c[6]), .g(c[7]));

  assign d    = p ^ {c[6:0], CIN};
  assign cout = c[7];
endmodule

// File: rtl/neuron_sad_subtract_accumulate.sv
// Streaming SAD engine: |a-b| per accepted pair, one summed result per frame.
module neuron_sad_subtract_accumulate
  import neuron_sad_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter int N_SAMPLES = 16,
  parameter int ACC_W     = acc_width(WIDTH, N_SAMPLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] sad,
  output logic             busy
);
  localparam int CNT_W = $clog2(N_SAMPLES);

  state_t state, state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] diff, abs_diff, s1_abs;
  logic             cout, s1_valid, s1_last;
  logic [ACC_W-1:0] acc, acc_sum;
  logic             accept, last_pair;

  sklansky_subtractor_8bit u_sub (
    .a   (a),
    .b   (b),
    .d   (diff),
    .cout(cout)
  );

  // A missing carry means a borrow, so the two's-complement negation gives |a-b|.
  assign abs_diff  = cout ? diff : (~diff + WIDTH'(1));
  assign accept    = in_valid && in_ready;
  assign last_pair = (count == CNT_W'(N_SAMPLES - 1));
  assign acc_sum   = acc + ACC_W'(s1_abs);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      s1_abs   <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      acc      <= '0;
      sad      <= '0;
    end else begin
      state    <= state_next;
      s1_valid <= accept;
      if (accept) begin
        s1_abs  <= abs_diff;
        s1_last <= last_pair;
        count   <= last_pair ? '0 : count + CNT_W'(1);
      end
      if (s1_valid) begin
        if (s1_last) begin
          sad <= acc_sum;
          acc <= '0;
        end else begin
          acc <= acc_sum;
        end
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = last_pair ? DRAIN : ACCUM;
      ACCUM:   if (accept && last_pair) state_next = DRAIN;
      DRAIN:   state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE) || (state == ACCUM);
  assign out_valid = (state == HOLD);
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_neuron_sad_subtract_accumulate.sv
// Scoreboard bench for the SAD engine plus an exhaustive check of the subtractor.
module tb_neuron_sad_subtract_accumulate;
  localparam int WIDTH = 8;
  localparam int N     = 16;
  localparam int ACC_W = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] sad;
  logic             busy;

  logic [7:0] sub_a = '0, sub_b = '0, sub_d;
  logic       sub_cout;

  int tests_run = 0;
  int tests_failed = 0;

  int exp_q[$];
  int model_sum = 0;
  int model_cnt = 0;
  int frames_done = 0;
  int lat = 0;
  bit frame_full = 1'b0;

  neuron_sad_subtract_accumulate #(.WIDTH(WIDTH), .N_SAMPLES(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sad      (sad),
    .busy     (busy)
  );

  sklansky_subtractor_8bit u_sub_ref (
    .a   (sub_a),
    .b   (sub_b),
    .d   (sub_d),
    .cout(sub_cout)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL global_timeout: got still running, expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int absDiff(input int x, input int y);
    return (x > y) ? x - y : y - x;
  endfunction

  // One cycle: drive at the falling edge, check outputs, then advance the model.
  task automatic applyStimulus(input bit v, input int av, input int bv, input bit ordy);
    bit exp_ov;
    @(negedge clk);
    in_valid  = v;
    a         = av[7:0];
    b         = bv[7:0];
    out_ready = ordy;
    #1;
    if (frame_full && lat < 3) lat++;
    exp_ov = frame_full && (lat >= 2);
    checkOutput("in_ready", in_ready, !frame_full);
    checkOutput("busy", busy, (model_cnt != 0) || frame_full);
    checkOutput("out_valid", out_valid, exp_ov);
    if (exp_ov && exp_q.size() > 0) checkOutput("sad", sad, exp_q[0]);
    if (exp_ov && ordy) begin
      void'(exp_q.pop_front());
      frame_full = 1'b0;
    end else if (v && !frame_full) begin
      model_sum += absDiff(av & 255, bv & 255);
      model_cnt++;
      if (model_cnt == N) begin
        exp_q.push_back(model_sum);
        model_sum   = 0;
        model_cnt   = 0;
        frame_full  = 1'b1;
        lat         = 0;
        frames_done++;
      end
    end
  endtask

  task automatic drainResult(input int bound);
    int n = 0;
    while (frame_full && n < bound) begin
      applyStimulus(1'b0, 0, 0, 1'b1);
      n++;
    end
    if (frame_full) checkOutput("drain_timeout", 1, 0);
  endtask

  task automatic doReset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_sad", sad, 0);
    checkOutput("rst_busy", busy, 0);
    exp_q.delete();
    model_sum = 0;
    model_cnt = 0;
    frame_full = 1'b0;
    lat = 0;
  endtask

  task automatic sendFrame(input int av, input int bv, input bit ordy);
    repeat (N) applyStimulus(1'b1, av, bv, ordy);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      for (int j = 0; j < 256; j++) begin
        sub_a = i[7:0];
        sub_b = j[7:0];
        #1;
        checkOutput("sub_d", sub_d, (i - j) & 255);
        checkOutput("sub_cout", sub_cout, (i >= j) ? 1 : 0);
      end
    end

    doReset(2);

    repeat (5) applyStimulus(1'b1, 10, 2, 1'b1);
    doReset(2);
    sendFrame(3, 1, 1'b1);
    drainResult(10);
    checkOutput("reset_frame_sad", sad, 32);

    sendFrame(200, 50, 1'b0);
    drainResult(10);
    checkOutput("frame_200_50", sad, 2400);

    sendFrame(0, 255, 1'b1);
    drainResult(10);
    checkOutput("borrow_max", sad, 4080);
    sendFrame(77, 77, 1'b1);
    drainResult(10);
    checkOutput("equal_zero", sad, 0);

    sendFrame(20, 5, 1'b0);
    repeat (12) applyStimulus(1'b1, 1, 2, 1'b0);
    repeat (N + 1) applyStimulus(1'b1, 9, 4, 1'b1);
    drainResult(10);
    checkOutput("backpressure_next", sad, 80);

    sendFrame(6, 1, 1'b0);
    repeat (3) applyStimulus(1'b0, 0, 0, 1'b0);
    doReset(1);
    sendFrame(1, 0, 1'b1);
    drainResult(10);
    checkOutput("after_hold_reset", sad, 16);

    for (int f = 0; f < 24; f++) begin
      int pos = $urandom_range(N - 1);
      int ra = $urandom_range(255);
      int rb = $urandom_range(255);
      for (int s = 0; s < N; s++) begin
        if (s == pos) applyStimulus(1'b1, ra, rb, 1'b1);
        else applyStimulus(1'b1, 0, 0, 1'b1);
      end
      drainResult(10);
      checkOutput("single_sample", sad, absDiff(ra, rb));
    end

    begin
      int target = frames_done + 100;
      int cycles = 0;
      while (frames_done < target && cycles < 40000) begin
        applyStimulus($urandom_range(99) < 40, $urandom_range(255), $urandom_range(255),
                      $urandom_range(1) == 1);
        cycles++;
      end
      if (frames_done < target) checkOutput("gapped_timeout", frames_done, target);
      drainResult(20);
    end

    checkOutput("queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
